// File: rtl/clk_meas_pkg.sv
`default_nettype none
// ==========================================================================
// clk_meas_pkg: shared state encoding and default width for clk_period_meter
// rev 1.0
// ==========================================================================
package clk_meas_pkg;

  localparam int CNT_W_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FIRST = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/edge_sync.sv
`default_nettype none
// ==========================================================================
// edge_sync: meas_in synchronizer chain plus delay flop for edge detection
// rev 1.0
// ==========================================================================
module edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic meas_in,
  output logic s,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] r_chain;
  logic                   r_prev;

  generate
    if (SYNC_STAGES == 1) begin : g_single
      always_ff @(posedge clk) begin
        if (rst) r_chain <= '0;
        else     r_chain <= meas_in;
      end
    end else begin : g_multi
      always_ff @(posedge clk) begin
        if (rst) r_chain <= '0;
        else     r_chain <= {r_chain[SYNC_STAGES-2:0], meas_in};
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) r_prev <= 1'b0;
    else     r_prev <= s;
  end

  assign s    = r_chain[SYNC_STAGES-1];
  assign rise = s & ~r_prev;
  assign fall = ~s & r_prev;

endmodule
`default_nettype wire

// File: rtl/clk_period_meter.sv
`default_nettype none
// ==========================================================================
// clk_period_meter: measures high/low/period of a slow input in clk cycles
// rev 1.0
// ==========================================================================
module clk_period_meter
  import clk_meas_pkg::*;
#(
  parameter int          CNT_W       = CNT_W_DEF,
  parameter int          SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT     = 32'hFFFFFF,
  parameter int          LOCK_CNT    = 4,
  parameter int unsigned TOL         = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic           meas_in,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] low_cnt,
  output logic [CNT_W:0]   period_cnt,
  output logic           meas_valid,
  output logic           locked,
  output logic           timeout
);

  localparam logic [CNT_W-1:0] c_TIMEOUT = CNT_W'(TIMEOUT);
  localparam logic [CNT_W:0]   c_TOL     = (CNT_W+1)'(TOL);
  localparam logic [3:0]       c_LOCK    = 4'(LOCK_CNT);

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_seg, w_seg_inc, r_high_cap;
  logic [CNT_W:0]     r_prev_period, w_period_new, w_diff;
  logic [3:0]         r_match_cnt, w_match_nxt;
  logic               r_have_high, r_have_prev;
  logic               w_s, w_rise, w_fall, w_edge, w_tmo, w_publish;

  edge_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .rst     (rst),
    .meas_in (meas_in),
    .s       (w_s),
    .rise    (w_rise),
    .fall    (w_fall)
  );

  assign w_edge       = w_rise | w_fall;
  assign w_seg_inc    = r_seg + CNT_W'(1);
  // An edge in the timeout cycle closes the level normally instead.
  assign w_tmo        = en && !w_edge && (w_seg_inc == c_TIMEOUT);
  assign w_period_new = (CNT_W+1)'(r_high_cap) + (CNT_W+1)'(w_seg_inc);
  assign w_diff       = (w_period_new >= r_prev_period) ? (w_period_new - r_prev_period)
                                                        : (r_prev_period - w_period_new);

  always_comb begin
    w_state_nxt = r_state;
    w_publish   = 1'b0;
    if (!en || w_tmo) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:  if (w_edge) w_state_nxt = ST_FIRST;
        ST_FIRST: if (w_edge) w_state_nxt = ST_RUN;
        ST_RUN:   w_publish = w_rise && r_have_high;
        default:  w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // The first period after IDLE only seeds the comparison.
  always_comb begin
    w_match_nxt = '0;
    if (!r_have_prev)
      w_match_nxt = r_match_cnt;
    else if (w_diff <= c_TOL)
      w_match_nxt = (r_match_cnt == c_LOCK) ? r_match_cnt : r_match_cnt + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_seg         <= '0;
      r_high_cap    <= '0;
      r_have_high   <= 1'b0;
      r_prev_period <= '0;
      r_have_prev   <= 1'b0;
      r_match_cnt   <= '0;
      high_cnt      <= '0;
      low_cnt       <= '0;
      period_cnt    <= '0;
      meas_valid    <= 1'b0;
      locked        <= 1'b0;
      timeout       <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      meas_valid <= w_publish;

      if (!en || w_edge)          r_seg <= '0;
      else if (r_seg != c_TIMEOUT) r_seg <= w_seg_inc;

      if (!en || w_tmo || r_state == ST_IDLE) begin
        r_have_high <= 1'b0;
        r_have_prev <= 1'b0;
        r_match_cnt <= '0;
        locked      <= 1'b0;
        if (w_tmo) timeout <= 1'b1;
      end else begin
        if (w_edge && !w_s) begin
          r_high_cap  <= w_seg_inc;
          r_have_high <= 1'b1;
          if (r_state == ST_RUN) high_cnt <= w_seg_inc;
        end
        if (w_publish) begin
          high_cnt      <= r_high_cap;
          low_cnt       <= w_seg_inc;
          period_cnt    <= w_period_new;
          timeout       <= 1'b0;
          r_prev_period <= w_period_new;
          r_have_prev   <= 1'b1;
          r_match_cnt   <= w_match_nxt;
          locked        <= (w_match_nxt == c_LOCK);
        end
      end
    end
  end

endmodule
`default_nettype wire
